// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C register-interface target.
package i2c_slave_pkg;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;
  localparam int PTR_W  = 8;
  localparam logic [7:0] GCALL_ADDR = 8'h00;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK,
    WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT
  } state_t;
endpackage

// File: rtl/i2c_slave_filter.sv
// SCL/SDA synchronizer, stability filter and bus-event detection.
module i2c_slave_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);
  localparam logic [2:0] LIM = 3'(FILTER_LEN - 1);

  logic [1:0] scl_sync, sda_sync;
  logic [2:0] scl_cnt, sda_cnt;
  logic       scl_f, sda_f, scl_q, sda_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_cnt  <= '0;
      sda_cnt  <= '0;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
      if (scl_sync[1] == scl_f) begin
        scl_cnt <= '0;
      end else if (scl_cnt == LIM) begin
        scl_f   <= scl_sync[1];
        scl_cnt <= '0;
      end else begin
        scl_cnt <= scl_cnt + 3'd1;
      end
      if (sda_sync[1] == sda_f) begin
        sda_cnt <= '0;
      end else if (sda_cnt == LIM) begin
        sda_f   <= sda_sync[1];
        sda_cnt <= '0;
      end else begin
        sda_cnt <= sda_cnt + 3'd1;
      end
      scl_q <= scl_f;
      sda_q <= sda_f;
    end
  end

  assign sda_o    = sda_f;
  assign scl_rise = scl_f & ~scl_q;
  assign scl_fall = ~scl_f & scl_q;
  // SDA edges only count as START/STOP while SCL was high on both samples
  assign start    = sda_q & ~sda_f & scl_f & scl_q;
  assign stop     = ~sda_q & sda_f & scl_f & scl_q;
endmodule

// File: rtl/i2c_slave_regif.sv
// I2C target giving an external master access to an 8-bit register space.
// Optional general call (address byte 0x00) enabled by I2C_SLAVE_GCALL_EN.
module i2c_slave_regif
  import i2c_slave_pkg::*;
#(
  parameter logic [ADDR_W-1:0] SLAVE_ADDR = 7'h2C,
  parameter int                FILTER_LEN = 3
) (
  input  logic              wb_clk_i,
  input  logic              arst_i,
  input  logic              scl_pad_i,
  input  logic              sda_pad_i,
  output logic              sda_pad_o,
  output logic              sda_padoen_o,
  output logic [PTR_W-1:0]  reg_addr_o,
  output logic [DATA_W-1:0] reg_wdata_o,
  output logic              reg_we_o,
  output logic              reg_re_o,
  input  logic [DATA_W-1:0] reg_rdata_i,
  output logic              busy_o
);
`ifdef I2C_SLAVE_GCALL_EN
  localparam bit GCALL_ON = 1'b1;
`else
  localparam bit GCALL_ON = 1'b0;
`endif
  localparam bit ZERO_ADDR = (SLAVE_ADDR == '0);

  state_t            state;
  logic [3:0]        bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic [PTR_W-1:0]  ptr;
  logic              rw, we_pend, cap_q, mack;
  logic              sda_f, scl_rise, scl_fall, start, stop;
  logic [DATA_W-1:0] shreg_nx;
  logic [2:0]        tx_idx;
  logic              addr_hit;

  i2c_slave_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
    .clk      (wb_clk_i),
    .rst_n    (arst_i),
    .scl_i    (scl_pad_i),
    .sda_i    (sda_pad_i),
    .sda_o    (sda_f),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  assign shreg_nx  = {shreg[DATA_W-2:0], sda_f};
  assign tx_idx    = 3'd7 - bit_cnt[2:0];
  assign sda_pad_o = 1'b0;
  assign addr_hit  = (shreg[7:1] == SLAVE_ADDR && !ZERO_ADDR) ||
                     (shreg == GCALL_ADDR && (GCALL_ON || ZERO_ADDR));

  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      shreg        <= '0;
      ptr          <= '0;
      rw           <= 1'b0;
      we_pend      <= 1'b0;
      cap_q        <= 1'b0;
      mack         <= 1'b0;
      sda_padoen_o <= 1'b1;
      reg_addr_o   <= '0;
      reg_wdata_o  <= '0;
      reg_we_o     <= 1'b0;
      reg_re_o     <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      reg_we_o <= 1'b0;
      reg_re_o <= 1'b0;
      cap_q    <= reg_re_o;
      if (we_pend) begin
        reg_we_o    <= 1'b1;
        reg_addr_o  <= ptr;
        reg_wdata_o <= shreg;
        ptr         <= ptr + 8'd1;
        we_pend     <= 1'b0;
      end
      // read data is valid the cycle after the strobe
      if (cap_q) begin
        shreg <= reg_rdata_i;
        ptr   <= ptr + 8'd1;
      end
      if (start) begin
        state        <= ADDR;
        bit_cnt      <= '0;
        mack         <= 1'b0;
        sda_padoen_o <= 1'b1;
        busy_o       <= 1'b1;
      end else if (stop) begin
        state        <= IDLE;
        sda_padoen_o <= 1'b1;
        busy_o       <= 1'b0;
      end else begin
        unique case (state)
          ADDR: begin
            if (scl_rise && bit_cnt != 4'd8) begin
              shreg   <= shreg_nx;
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              rw <= shreg[0];
              if (addr_hit) begin
                state        <= ADDR_ACK;
                sda_padoen_o <= 1'b0;
              end else begin
                state <= WAIT;
              end
            end
          end
          PTR, WDATA: begin
            if (scl_rise && bit_cnt != 4'd8) begin
              shreg   <= shreg_nx;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                if (state == PTR) ptr <= shreg_nx;
                else we_pend <= 1'b1;
              end
            end else if (scl_fall && bit_cnt == 4'd8) begin
              state        <= (state == PTR) ? PTR_ACK : WDATA_ACK;
              sda_padoen_o <= 1'b0;
            end
          end
          ADDR_ACK: begin
            if (scl_rise && rw) begin
              reg_re_o   <= 1'b1;
              reg_addr_o <= ptr;
            end else if (scl_fall) begin
              bit_cnt      <= '0;
              state        <= rw ? RDATA : PTR;
              sda_padoen_o <= rw ? shreg[7] : 1'b1;
            end
          end
          PTR_ACK, WDATA_ACK: begin
            if (scl_fall) begin
              state        <= WDATA;
              bit_cnt      <= '0;
              sda_padoen_o <= 1'b1;
            end
          end
          RDATA: begin
            if (scl_rise && bit_cnt != 4'd8) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                state        <= RDATA_ACK;
                sda_padoen_o <= 1'b1;
              end else begin
                sda_padoen_o <= shreg[tx_idx];
              end
            end
          end
          RDATA_ACK: begin
            if (scl_rise) begin
              if (!sda_f) begin
                reg_re_o   <= 1'b1;
                reg_addr_o <= ptr;
                mack       <= 1'b1;
              end else begin
                state <= WAIT;
              end
            end else if (scl_fall && mack) begin
              state        <= RDATA;
              mack         <= 1'b0;
              bit_cnt      <= '0;
              sda_padoen_o <= shreg[7];
            end
          end
          default: sda_padoen_o <= 1'b1;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_slave_regif.sv
// Directed bench for i2c_slave_regif: bit-banged I2C master plus register model.
`timescale 1ns/1ps
module tb_i2c_slave_regif;
  localparam time Q = 100ns;

  logic       clk = 1'b0;
  logic       arst_i = 1'b0;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  wire        sda;
  logic       sda_pad_o, sda_padoen_o;
  logic [7:0] reg_addr_o, reg_wdata_o, reg_rdata;
  logic       reg_we_o, reg_re_o, busy_o;

  logic [7:0]  mem [256];
  logic [15:0] wq[$];
  logic [7:0]  rq[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          both = 0;
  logic        pulled = 1'b0;

  always #5 clk = ~clk;

  assign sda = sda_m & (sda_padoen_o | sda_pad_o);

  i2c_slave_regif dut (
    .wb_clk_i     (clk),
    .arst_i       (arst_i),
    .scl_pad_i    (scl),
    .sda_pad_i    (sda),
    .sda_pad_o    (sda_pad_o),
    .sda_padoen_o (sda_padoen_o),
    .reg_addr_o   (reg_addr_o),
    .reg_wdata_o  (reg_wdata_o),
    .reg_we_o     (reg_we_o),
    .reg_re_o     (reg_re_o),
    .reg_rdata_i  (reg_rdata),
    .busy_o       (busy_o)
  );

  always @(posedge clk) if (reg_re_o) reg_rdata <= mem[reg_addr_o];

  always @(negedge clk) begin
    if (reg_we_o) wq.push_back({reg_addr_o, reg_wdata_o});
    if (reg_re_o) rq.push_back(reg_addr_o);
    if (reg_we_o && reg_re_o) both++;
    if (!sda_padoen_o) pulled = 1'b1;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; #Q;
    scl = 1'b1;   #Q;
    sda_m = 1'b0; #Q;
    scl = 1'b0;   #Q;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #Q;
    scl = 1'b1;   #Q;
    sda_m = 1'b1; #Q;
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; #Q;
    scl = 1'b1; #Q; #Q;
    scl = 1'b0; #Q;
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; #Q;
    scl = 1'b1; #Q;
    b = sda; #Q;
    scl = 1'b0; #Q;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(b);
    ack = ~b;
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(~ack);
  endtask

  typedef struct {
    logic [7:0] abyte;
    logic [7:0] ptr;
    logic [7:0] d0;
    logic [7:0] d1;
    int         nd;
    logic       exp_ack;
    int         exp_nw;
    logic [7:0] exp_a0;
    logic [7:0] exp_a1;
  } wvec_t;

  wvec_t vecs[6];

  initial begin
    logic       ack;
    logic       b;
    logic [7:0] d;

    for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'hA5);
    mem[8'h20] = 8'h5A;
    mem[8'h21] = 8'hC3;
    mem[8'h30] = 8'h00;

    vecs[0] = '{8'h58, 8'h10, 8'hAA, 8'hBB, 2, 1'b1, 2, 8'h10, 8'h11};
    vecs[1] = '{8'h5A, 8'h33, 8'h00, 8'h00, 1, 1'b0, 0, 8'h00, 8'h00};
    vecs[2] = '{8'h58, 8'hFF, 8'h01, 8'h02, 2, 1'b1, 2, 8'hFF, 8'h00};
`ifdef I2C_SLAVE_GCALL_EN
    vecs[3] = '{8'h00, 8'h05, 8'h77, 8'h00, 1, 1'b1, 1, 8'h05, 8'h00};
`else
    vecs[3] = '{8'h00, 8'h05, 8'h77, 8'h00, 1, 1'b0, 0, 8'h00, 8'h00};
`endif
    vecs[4] = '{8'h01, 8'h05, 8'h66, 8'h00, 1, 1'b0, 0, 8'h00, 8'h00};
    vecs[5] = '{8'h58, 8'h7E, 8'h3C, 8'h00, 1, 1'b1, 1, 8'h7E, 8'h00};

    repeat (5) @(posedge clk);
    #1;
    check("rst_padoen", sda_padoen_o, 1);
    check("rst_we", reg_we_o, 0);
    check("rst_re", reg_re_o, 0);
    check("rst_addr", reg_addr_o, 0);
    check("rst_wdata", reg_wdata_o, 0);
    check("rst_busy", busy_o, 0);
    arst_i = 1'b1;
    repeat (10) @(posedge clk);

    for (int v = 0; v < 6; v++) begin
      wq.delete();
      rq.delete();
      pulled = 1'b0;
      i2c_start();
      check($sformatf("v%0d_busy", v), busy_o, 1);
      write_byte(vecs[v].abyte, ack);
      check($sformatf("v%0d_addr_ack", v), ack, vecs[v].exp_ack);
      if (ack) begin
        write_byte(vecs[v].ptr, ack);
        check($sformatf("v%0d_ptr_ack", v), ack, 1);
        write_byte(vecs[v].d0, ack);
        check($sformatf("v%0d_d0_ack", v), ack, 1);
        if (vecs[v].nd > 1) begin
          write_byte(vecs[v].d1, ack);
          check($sformatf("v%0d_d1_ack", v), ack, 1);
        end
      end else begin
        check($sformatf("v%0d_no_pull", v), pulled, 0);
      end
      i2c_stop();
      repeat (10) @(negedge clk);
      check($sformatf("v%0d_idle", v), busy_o, 0);
      check($sformatf("v%0d_nwr", v), wq.size(), vecs[v].exp_nw);
      check($sformatf("v%0d_nrd", v), rq.size(), 0);
      if (vecs[v].exp_nw >= 1 && wq.size() >= 1)
        check($sformatf("v%0d_w0", v), wq[0], {vecs[v].exp_a0, vecs[v].d0});
      if (vecs[v].exp_nw >= 2 && wq.size() >= 2)
        check($sformatf("v%0d_w1", v), wq[1], {vecs[v].exp_a1, vecs[v].d1});
    end

    // pointer write, repeated START, two-byte read ending in NACK
    wq.delete();
    rq.delete();
    i2c_start();
    write_byte(8'h58, ack);
    check("rd_aw_ack", ack, 1);
    write_byte(8'h20, ack);
    check("rd_ptr_ack", ack, 1);
    i2c_start();
    write_byte(8'h59, ack);
    check("rd_ar_ack", ack, 1);
    read_byte(d, 1'b1);
    check("rd_byte0", d, 8'h5A);
    read_byte(d, 1'b0);
    check("rd_byte1", d, 8'hC3);
    check("rd_release", sda_padoen_o, 1);
    i2c_stop();
    repeat (10) @(negedge clk);
    check("rd_nrd", rq.size(), 2);
    if (rq.size() >= 2) begin
      check("rd_a0", rq[0], 8'h20);
      check("rd_a1", rq[1], 8'h21);
    end
    check("rd_nwr", wq.size(), 0);
    check("rd_idle", busy_o, 0);

    // reset in the middle of a read byte
    i2c_start();
    write_byte(8'h58, ack);
    write_byte(8'h30, ack);
    i2c_start();
    write_byte(8'h59, ack);
    check("rst_ar_ack", ack, 1);
    for (int i = 0; i < 4; i++) read_bit(b);
    check("rst_pre_drive", sda_padoen_o, 0);
    arst_i = 1'b0;
    #1;
    check("rst_mid_padoen", sda_padoen_o, 1);
    check("rst_mid_busy", busy_o, 0);
    repeat (5) @(posedge clk);
    arst_i = 1'b1;
    repeat (5) @(posedge clk);
    i2c_stop();
    wq.delete();
    i2c_start();
    write_byte(8'h58, ack);
    check("post_rst_ack", ack, 1);
    write_byte(8'h44, ack);
    write_byte(8'h99, ack);
    check("post_rst_d_ack", ack, 1);
    i2c_stop();
    repeat (10) @(negedge clk);
    check("post_rst_nwr", wq.size(), 1);
    if (wq.size() >= 1) check("post_rst_w0", wq[0], 16'h4499);
    check("we_re_excl", both, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
